// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// bit-counter sizing.
package serial_adder_pkg;

    // Sequencer states; encodings kept identical to the legacy include.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Width of the bit counter for a WIDTH-bit operation.
    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Handshake and data bundle for serial_adder.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the 'sub' request bit.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (output start, a, b, sub, input busy, done, sum, cout);
    modport slave  (input start, a, b, sub, output busy, done, sum, cout);
`else
    modport master (output start, a, b, input busy, done, sum, cout);
    modport slave  (input start, a, b, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder_full_adder_bit.sv
// Single-bit full adder built from two half adders and an OR on the carries.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic s0;
    logic c0;
    logic c1;

    halfAdder u_ha0 (.a(a),  .b(b),   .s(s0), .c(c0));
    halfAdder u_ha1 (.a(s0), .b(cin), .s(s),  .c(c1));

    assign cout = c0 | c1;
endmodule

// File: rtl/serial_adder_half_adder.sv
// Single-bit half adder cell.
module halfAdder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, carry held in a flop,
// one bit pair per clock LSB first, start/busy/done handshake.
// Optional feature macro: SERIAL_ADDER_SUB_EN (subtract via inverted b, carry-in 1).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);
    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] b_load;
    logic             carry_init;
    logic [WIDTH-1:0] r_next;

    full_adder_bit u_fa (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .cin (carry),
        .s   (fa_s),
        .cout(fa_c)
    );

    // Operand-B and carry-in values applied when a request is accepted.
    always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
        b_load     = bus.sub ? ~bus.b : bus.b;
        carry_init = bus.sub;
`else
        b_load     = bus.b;
        carry_init = 1'b0;
`endif
        r_next = {fa_s, r_sh[WIDTH-1:1]};
    end

    // Sequencer and datapath: accept, shift WIDTH bits, publish result for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            r_sh   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            sum_r  <= '0;
            cout_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_sh   <= bus.a;
                        b_sh   <= b_load;
                        carry  <= carry_init;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= ST_SHIFT;
                    end else begin
                        busy_r <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    carry <= fa_c;
                    r_sh  <= r_next;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum_r  <= r_next;
                        cout_r <= fa_c;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8).
`timescale 1ns/100ps
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   lat;
    int   busy_cnt;
    int   done_cnt;

    serial_adder_if #(.WIDTH(8)) bus ();

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #1 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue a one-cycle start, wait (bounded) for done; records latency and busy cycles.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sub);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub   = sub;
`else
        if (sub) $display("note: sub ignored in add-only build");
`endif
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        lat      = 0;
        busy_cnt = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.busy === 1'b1) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub   = 1'b0;
`endif
        #5;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_sum",  32'(bus.sum),  32'h00);
        @(negedge clk);
        rst = 1'b0;

        // FF + 01: wrap with carry out, 8-cycle latency
        run_op(8'hFF, 8'h01, 1'b0);
        check("ff01_latency", 32'(lat), 32'd8);
        check("ff01_busy_cycles", 32'(busy_cnt), 32'd8);
        check("ff01_sum",  32'(bus.sum),  32'h00);
        check("ff01_cout", 32'(bus.cout), 32'd1);
        check("ff01_busy_at_done", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check("ff01_done_pulse", 32'(bus.done), 32'd0);
        check("ff01_sum_hold",   32'(bus.sum),  32'h00);

        // A5 + 5A, then 80 + 80
        run_op(8'hA5, 8'h5A, 1'b0);
        check("a55a_sum",  32'(bus.sum),  32'hFF);
        check("a55a_cout", 32'(bus.cout), 32'd0);
        run_op(8'h80, 8'h80, 1'b0);
        check("8080_sum",  32'(bus.sum),  32'h00);
        check("8080_cout", 32'(bus.cout), 32'd1);

        // reset pulse with no operation pending
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstidle_busy", 32'(bus.busy), 32'd0);
        check("rstidle_done", 32'(bus.done), 32'd0);
        check("rstidle_sum",  32'(bus.sum),  32'h00);
        check("rstidle_cout", 32'(bus.cout), 32'd0);

        // start pulsed 3 cycles into an op must be ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 8'h12;
        bus.b = 8'h34;
        @(negedge clk);
        bus.start = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 3) begin
                bus.start = 1'b1;
                bus.a = 8'h77;
                bus.b = 8'h77;
            end else begin
                bus.start = 1'b0;
            end
            if (i == 8) check("ignore_sum", 32'(bus.sum), 32'h46);
            if (bus.done === 1'b1) done_cnt++;
            @(negedge clk);
        end
        check("ignore_done_count", 32'(done_cnt), 32'd1);
        check("ignore_sum_final",  32'(bus.sum),  32'h46);
        check("ignore_idle_busy",  32'(bus.busy), 32'd0);

        // reset at cycle 4 of an op aborts at once
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 8'h10;
        bus.b = 8'h20;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #0.5;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_sum",  32'(bus.sum),  32'h00);
        check("abort_cout", 32'(bus.cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_no_done", 32'(bus.done), 32'd0);
        run_op(8'h03, 8'h04, 1'b0);
        check("after_abort_latency", 32'(lat), 32'd8);
        check("after_abort_sum",  32'(bus.sum),  32'h07);
        check("after_abort_cout", 32'(bus.cout), 32'd0);

        // start held through DONE: back-to-back op without idle cycle
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 8'h01;
        bus.b = 8'h02;
        @(negedge clk);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_first_latency", 32'(lat), 32'd8);
        check("b2b_first_sum", 32'(bus.sum), 32'h03);
        bus.a = 8'h10;
        bus.b = 8'h0F;
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b_busy_no_gap", 32'(bus.busy), 32'd1);
        check("b2b_done_drop",   32'(bus.done), 32'd0);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_second_latency", 32'(lat), 32'd8);
        check("b2b_second_sum",  32'(bus.sum),  32'h1F);
        check("b2b_second_cout", 32'(bus.cout), 32'd0);

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h05, 8'h03, 1'b1);
        check("sub_0503_sum",  32'(bus.sum),  32'h02);
        check("sub_0503_cout", 32'(bus.cout), 32'd1);
        run_op(8'h03, 8'h05, 1'b1);
        check("sub_0305_sum",  32'(bus.sum),  32'hFE);
        check("sub_0305_cout", 32'(bus.cout), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
